// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - CPU control bus between the microcoded sequencer and the datapath
interface control_sequencer_if;
    logic [3:0] opcode;
    logic       zero;
    logic       carry;
    logic [2:0] step;
    logic       halt;
    logic       addressWEN;
    logic       ramWEN;
    logic       ramREN;
    logic       iWEN;
    logic       iREN;
    logic       aWEN;
    logic       aREN;
    logic       aluREN;
    logic       sub;
    logic       bWEN;
    logic       outputWEN;
    logic       pcEN;
    logic       pcREN;
    logic       jump;
    logic       flagWEN;

    modport master (
        input  opcode, zero, carry,
        output step, halt, addressWEN, ramWEN, ramREN, iWEN, iREN, aWEN, aREN,
               aluREN, sub, bWEN, outputWEN, pcEN, pcREN, jump, flagWEN
    );

    modport slave (
        output opcode, zero, carry,
        input  step, halt, addressWEN, ramWEN, ramREN, iWEN, iREN, aWEN, aREN,
               aluREN, sub, bWEN, outputWEN, pcEN, pcREN, jump, flagWEN
    );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - microcoded T-state sequencer driving the CPU control bus
module control_sequencer #(
    parameter int NSTEPS    = 5,
    parameter bit EARLY_END = 1'b1
) (
    input  logic                CLK,
    input  logic                RST,
    control_sequencer_if.master bus
);
    localparam int SW = $clog2(NSTEPS);

    localparam logic [SW-1:0] T0    = SW'(0);
    localparam logic [SW-1:0] T1    = SW'(1);
    localparam logic [SW-1:0] T2    = SW'(2);
    localparam logic [SW-1:0] T3    = SW'(3);
    localparam logic [SW-1:0] T4    = SW'(4);
    localparam logic [SW-1:0] TLAST = SW'(NSTEPS - 1);

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
        OP_STA = 4'h4, OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7,
        OP_JZ  = 4'h8, OP_OUT = 4'hE, OP_HLT = 4'hF
    } opcode_t;

    logic [SW-1:0] stepR;
    logic          haltR;
    logic [SW-1:0] lastStep;
    opcode_t       op;

    assign op       = opcode_t'(bus.opcode);
    assign bus.step = 3'(stepR);

    always_comb begin
        lastStep = T2;
        case (op)
            OP_LDA, OP_STA: lastStep = T3;
            OP_ADD, OP_SUB: lastStep = T4;
            default:        lastStep = T2;
        endcase
    end

    // Once halted the counter freezes; only reset brings the sequencer back.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stepR <= T0;
            haltR <= 1'b0;
        end else if (!haltR) begin
            if (stepR == T2 && op == OP_HLT)
                haltR <= 1'b1;
            else if (EARLY_END && stepR == lastStep)
                stepR <= T0;
            else if (stepR == TLAST)
                stepR <= T0;
            else
                stepR <= stepR + SW'(1);
        end
    end

    always_comb begin
        bus.halt       = 1'b0;
        bus.addressWEN = 1'b0;
        bus.ramWEN     = 1'b0;
        bus.ramREN     = 1'b0;
        bus.iWEN       = 1'b0;
        bus.iREN       = 1'b0;
        bus.aWEN       = 1'b0;
        bus.aREN       = 1'b0;
        bus.aluREN     = 1'b0;
        bus.sub        = 1'b0;
        bus.bWEN       = 1'b0;
        bus.outputWEN  = 1'b0;
        bus.pcEN       = 1'b0;
        bus.pcREN      = 1'b0;
        bus.jump       = 1'b0;
        bus.flagWEN    = 1'b0;
        if (!RST) begin
            if (haltR) begin
                bus.halt = 1'b1;
            end else begin
                case (stepR)
                    T0: begin
                        bus.pcREN      = 1'b1;
                        bus.addressWEN = 1'b1;
                    end
                    T1: begin
                        bus.ramREN = 1'b1;
                        bus.iWEN   = 1'b1;
                        bus.pcEN   = 1'b1;
                    end
                    T2: begin
                        case (op)
                            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                                bus.iREN       = 1'b1;
                                bus.addressWEN = 1'b1;
                            end
                            OP_LDI: begin
                                bus.iREN = 1'b1;
                                bus.aWEN = 1'b1;
                            end
                            OP_JMP: begin
                                bus.iREN = 1'b1;
                                bus.jump = 1'b1;
                            end
                            // Conditional jumps look at the flags only in this step.
                            OP_JC: begin
                                bus.iREN = bus.carry;
                                bus.jump = bus.carry;
                            end
                            OP_JZ: begin
                                bus.iREN = bus.zero;
                                bus.jump = bus.zero;
                            end
                            OP_OUT: begin
                                bus.aREN      = 1'b1;
                                bus.outputWEN = 1'b1;
                            end
                            OP_HLT:  bus.halt = 1'b1;
                            default: ;
                        endcase
                    end
                    T3: begin
                        case (op)
                            OP_LDA: begin
                                bus.ramREN = 1'b1;
                                bus.aWEN   = 1'b1;
                            end
                            OP_ADD, OP_SUB: begin
                                bus.ramREN = 1'b1;
                                bus.bWEN   = 1'b1;
                                bus.sub    = (op == OP_SUB);
                            end
                            OP_STA: begin
                                bus.aREN   = 1'b1;
                                bus.ramWEN = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    T4: begin
                        if (op == OP_ADD || op == OP_SUB) begin
                            bus.aluREN  = 1'b1;
                            bus.aWEN    = 1'b1;
                            bus.flagWEN = 1'b1;
                            bus.sub     = (op == OP_SUB);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    a_oneReader: assert property (@(posedge CLK) disable iff (RST)
        $onehot0({bus.ramREN, bus.iREN, bus.aREN, bus.aluREN, bus.pcREN}));
    a_ramRw: assert property (@(posedge CLK) disable iff (RST)
        !(bus.ramWEN && bus.ramREN));
    a_jumpPc: assert property (@(posedge CLK) disable iff (RST)
        !(bus.jump && bus.pcEN));
endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer, EARLY_END on and off
module tb_control_sequencer;
    localparam logic [15:0] HALT = 16'h8000, ADDRW = 16'h4000, RAMW = 16'h2000, RAMR = 16'h1000;
    localparam logic [15:0] IW   = 16'h0800, IR    = 16'h0400, AW   = 16'h0200, AR   = 16'h0100;
    localparam logic [15:0] ALUR = 16'h0080, SUBM  = 16'h0040, BW   = 16'h0020, OUTW = 16'h0010;
    localparam logic [15:0] PCE  = 16'h0008, PCR   = 16'h0004, JMP  = 16'h0002, FLW  = 16'h0001;

    logic CLK = 1'b0;
    logic rstA, rstB;
    int   errors = 0;
    int   checks = 0;

    always #5 CLK = ~CLK;

    control_sequencer_if busA ();
    control_sequencer_if busB ();

    control_sequencer #(.NSTEPS(5), .EARLY_END(1'b1)) dutA (.CLK(CLK), .RST(rstA), .bus(busA));
    control_sequencer #(.NSTEPS(5), .EARLY_END(1'b0)) dutB (.CLK(CLK), .RST(rstB), .bus(busB));

    typedef struct {
        string       tag;
        bit          dut;
        logic [2:0]  step;
        logic [15:0] word;
    } exp_t;

    exp_t sb[$];

    function automatic logic [15:0] wordOf(bit d);
        if (d)
            return {busB.halt, busB.addressWEN, busB.ramWEN, busB.ramREN, busB.iWEN, busB.iREN,
                    busB.aWEN, busB.aREN, busB.aluREN, busB.sub, busB.bWEN, busB.outputWEN,
                    busB.pcEN, busB.pcREN, busB.jump, busB.flagWEN};
        return {busA.halt, busA.addressWEN, busA.ramWEN, busA.ramREN, busA.iWEN, busA.iREN,
                busA.aWEN, busA.aREN, busA.aluREN, busA.sub, busA.bWEN, busA.outputWEN,
                busA.pcEN, busA.pcREN, busA.jump, busA.flagWEN};
    endfunction

    task automatic push(input string tag, input bit d, input logic [2:0] s, input logic [15:0] w);
        exp_t e;
        e.tag = tag; e.dut = d; e.step = s; e.word = w;
        sb.push_back(e);
    endtask

    task automatic pushFetch(input string tag, input bit d);
        push({tag, " T0"}, d, 3'd0, PCR | ADDRW);
        push({tag, " T1"}, d, 3'd1, RAMR | IW | PCE);
    endtask

    task automatic compareNow();
        exp_t        e;
        logic [2:0]  obsStep;
        logic [15:0] obsWord;
        e       = sb.pop_front();
        obsStep = e.dut ? busB.step : busA.step;
        obsWord = wordOf(e.dut);
        checks++;
        assert (obsStep === e.step) else begin
            errors++;
            $error("FAIL %s step: got %0d want %0d", e.tag, obsStep, e.step);
        end
        checks++;
        assert (obsWord === e.word) else begin
            errors++;
            $error("FAIL %s word: got %h want %h", e.tag, obsWord, e.word);
        end
    endtask

    // One queued expectation per clock cycle, sampled on the falling edge.
    task automatic drain();
        while (sb.size() > 0) begin
            @(negedge CLK);
            compareNow();
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        rstA = 1'b1; rstB = 1'b1;
        busA.opcode = 4'h0; busA.zero = 1'b0; busA.carry = 1'b0;
        busB.opcode = 4'h0; busB.zero = 1'b0; busB.carry = 1'b0;
        @(posedge CLK); #1;
        push("rstA", 0, 3'd0, 16'h0);
        push("rstA", 0, 3'd0, 16'h0);
        push("rstB", 1, 3'd0, 16'h0);
        drain();

        busA.opcode = 4'b0010; rstA = 1'b0;
        pushFetch("add", 0);
        push("add T2", 0, 3'd2, IR | ADDRW);
        push("add T3", 0, 3'd3, RAMR | BW);
        push("add T4", 0, 3'd4, ALUR | AW | FLW);
        drain();

        busA.opcode = 4'b0011;
        pushFetch("sub", 0);
        push("sub T2", 0, 3'd2, IR | ADDRW);
        push("sub T3", 0, 3'd3, RAMR | BW | SUBM);
        push("sub T4", 0, 3'd4, ALUR | AW | FLW | SUBM);
        drain();

        busA.opcode = 4'b0001;
        pushFetch("lda", 0);
        push("lda T2", 0, 3'd2, IR | ADDRW);
        push("lda T3", 0, 3'd3, RAMR | AW);
        drain();

        busA.opcode = 4'b0111; busA.carry = 1'b0;
        pushFetch("jc0", 0);
        push("jc0 T2", 0, 3'd2, 16'h0);
        drain();

        busA.carry = 1'b1;
        pushFetch("jc1", 0);
        push("jc1 T2", 0, 3'd2, IR | JMP);
        drain();

        busA.opcode = 4'b1000; busA.zero = 1'b1; busA.carry = 1'b0;
        pushFetch("jz1", 0);
        push("jz1 T2", 0, 3'd2, IR | JMP);
        drain();

        busA.opcode = 4'b1110;
        pushFetch("out", 0);
        push("out T2", 0, 3'd2, AR | OUTW);
        drain();

        busA.opcode = 4'b1010;
        pushFetch("undef", 0);
        push("undef T2", 0, 3'd2, 16'h0);
        drain();

        busA.opcode = 4'b0100;
        pushFetch("sta", 0);
        push("sta T2", 0, 3'd2, IR | ADDRW);
        drain();
        push("sta T3", 0, 3'd3, AR | RAMW);
        compareNow();
        rstA = 1'b1;
        #1;
        push("sta rst", 0, 3'd0, 16'h0);
        compareNow();
        @(posedge CLK); #1;
        rstA = 1'b0;

        busA.opcode = 4'b1111;
        pushFetch("hlt", 0);
        push("hlt T2", 0, 3'd2, HALT);
        for (int i = 0; i < 20; i++) push("hlt hold", 0, 3'd2, HALT);
        drain();
        rstA = 1'b1;
        #1;
        push("hlt rst", 0, 3'd0, 16'h0);
        compareNow();
        @(posedge CLK); #1;
        rstA = 1'b0;
        pushFetch("post hlt", 0);
        drain();

        busB.opcode = 4'b0101; rstB = 1'b0;
        pushFetch("ldi full", 1);
        push("ldi full T2", 1, 3'd2, IR | AW);
        push("ldi full T3", 1, 3'd3, 16'h0);
        push("ldi full T4", 1, 3'd4, 16'h0);
        push("ldi wrap", 1, 3'd0, PCR | ADDRW);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
